// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for data-RAM bus ports: arbiter modes, master ids and
// the request bundle a master presents to the RAM.
package data_ram_arbiter_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_SEL_W  = 4;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_SEL_W-1:0]  sel;
    } mem_req_t;

    function automatic mem_req_t pick_req(master_e owner, mem_req_t r0, mem_req_t r1);
        return (owner == MST_M1) ? r1 : r0;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin or m0-priority with an m1 starvation guard.
// Holds the last-grant pointer and the m1 wait counter.
module rr_arb2
    import data_ram_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = ARB_RR,
    parameter int MAX_WAIT  = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    master_e    last_q, last_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       m0_first;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        m0_first = (PRIO_MODE == ARB_FIXED) ? (wait_cnt_q != MAX_WAIT_C)
                                            : (last_q == MST_M1);
        o_gnt0   = ~i_rst & i_req0 & (~i_req1 | m0_first);
        o_gnt1   = ~i_rst & i_req1 & ~o_gnt0;

        last_d = last_q;
        if (o_gnt0) begin
            last_d = MST_M0;
        end else if (o_gnt1) begin
            last_d = MST_M1;
        end

        // Counter only runs while m1 is actually being held off.
        wait_cnt_d = '0;
        if ((PRIO_MODE == ARB_FIXED) && i_req1 && !o_gnt1) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q     <= MST_M1;
            wait_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one single-port data RAM between m0 (CPU) and m1 (DMA/debug).
// Grant in T, registered RAM access in T+1, read data returned in T+2.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = ARB_RR,
    parameter int MAX_WAIT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [3:0]        i_m0_sel,
    output logic              o_m0_gnt,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_rvalid,

    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [3:0]        i_m1_sel,
    output logic              o_m1_gnt,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_rvalid,

    output logic              o_ram_ce,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic [3:0]        o_ram_sel,
    input  logic [DATA_W-1:0] i_ram_data
);

    logic     gnt0, gnt1, gnt_any, rd_fire;
    mem_req_t m0_req, m1_req;

    mem_req_t          ram_req_q, ram_req_d;
    logic              ram_ce_q, ram_ce_d;
    master_e           ram_own_q, ram_own_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    rr_arb2 #(
        .PRIO_MODE (PRIO_MODE),
        .MAX_WAIT  (MAX_WAIT)
    ) u_arb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req0 (i_m0_req),
        .i_req1 (i_m1_req),
        .o_gnt0 (gnt0),
        .o_gnt1 (gnt1)
    );

    always_comb begin
        m0_req  = '{we: i_m0_we, addr: MEM_ADDR_W'(i_m0_addr),
                    wdata: MEM_DATA_W'(i_m0_wdata), sel: i_m0_sel};
        m1_req  = '{we: i_m1_we, addr: MEM_ADDR_W'(i_m1_addr),
                    wdata: MEM_DATA_W'(i_m1_wdata), sel: i_m1_sel};
        gnt_any = gnt0 | gnt1;

        // Idle cycles keep address/data/sel stable and only drop ce/we.
        ram_ce_d     = gnt_any;
        ram_req_d    = ram_req_q;
        ram_req_d.we = 1'b0;
        ram_own_d    = ram_own_q;
        if (gnt_any) begin
            ram_own_d = gnt1 ? MST_M1 : MST_M0;
            ram_req_d = pick_req(ram_own_d, m0_req, m1_req);
        end

        rd_fire   = ram_ce_q & ~ram_req_q.we;
        rvalid0_d = rd_fire & (ram_own_q == MST_M0);
        rvalid1_d = rd_fire & (ram_own_q == MST_M1);
        rdata0_d  = rvalid0_d ? i_ram_data : rdata0_q;
        rdata1_d  = rvalid1_d ? i_ram_data : rdata1_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ram_req_q <= '0;
            ram_ce_q  <= 1'b0;
            ram_own_q <= MST_M0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            ram_req_q <= ram_req_d;
            ram_ce_q  <= ram_ce_d;
            ram_own_q <= ram_own_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign o_m0_gnt    = gnt0;
    assign o_m1_gnt    = gnt1;
    assign o_m0_rvalid = rvalid0_q;
    assign o_m1_rvalid = rvalid1_q;
    assign o_m0_rdata  = rdata0_q;
    assign o_m1_rdata  = rdata1_q;
    assign o_ram_ce    = ram_ce_q;
    assign o_ram_we    = ram_req_q.we;
    assign o_ram_addr  = ram_req_q.addr[ADDR_W-1:0];
    assign o_ram_data  = ram_req_q.wdata[DATA_W-1:0];
    assign o_ram_sel   = ram_req_q.sel;

endmodule
